// File: rtl/csa_seq_adder.sv
// ============================================================================
//  Module   : csa_seq_adder
//  Purpose  : Multi-cycle carry-select adder, one BLOCK-bit slice per clock,
//             with a START/BUSY/DONE handshake. The optional OVF port is
//             enabled by defining CSA_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module csa_seq_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
`ifdef CSA_OVF_EN
  output logic             OVF,
`endif
  output logic             COUT
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBLK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;

  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic [BLOCK-1:0] a_slc;
  logic [BLOCK-1:0] b_slc;
  logic [BLOCK:0]   s0;
  logic [BLOCK:0]   s1;
  logic [BLOCK:0]   sel;
  int               base;
`ifdef CSA_OVF_EN
  logic             ovf_d;
`endif

  // Both candidate sums are formed every cycle; the registered carry picks one.
  always_comb begin
    base    = int'(idx_q) * BLOCK;
    a_slc   = a_q[base +: BLOCK];
    b_slc   = b_q[base +: BLOCK];
    s0      = {1'b0, a_slc} + {1'b0, b_slc};
    s1      = s0 + {{BLOCK{1'b0}}, 1'b1};
    sel     = carry_q ? s1 : s0;
    res_d   = res_q;
    res_d[base +: BLOCK] = sel[BLOCK-1:0];
    carry_d = sel[BLOCK];
`ifdef CSA_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_d[WIDTH-1]) ^ carry_d;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      SUM     <= '0;
      COUT    <= 1'b0;
`ifdef CSA_OVF_EN
      OVF     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= CIN;
            idx_q   <= '0;
            res_q   <= '0;
            BUSY    <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          res_q   <= res_d;
          carry_q <= carry_d;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            SUM     <= res_d;
            COUT    <= carry_d;
`ifdef CSA_OVF_EN
            OVF     <= ovf_d;
`endif
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            state_q <= S_FIN;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_FIN: begin
          DONE    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csa_seq_adder.sv
// ============================================================================
//  Module   : tb_csa_seq_adder
//  Purpose  : Directed self-checking bench for csa_seq_adder (WIDTH=16,
//             BLOCK=4). OVF checks are compiled in when CSA_OVF_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csa_seq_adder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] A;
  logic [15:0] B;
  logic        CIN;
  logic        BUSY;
  logic        DONE;
  logic [15:0] SUM;
  logic        COUT;
`ifdef CSA_OVF_EN
  logic        OVF;
`endif

  int n_vec = 0;
  int n_err = 0;

  csa_seq_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
`ifdef CSA_OVF_EN
    .OVF   (OVF),
`endif
    .COUT  (COUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec,
                         input logic eo);
    logic [15:0] prev;
    @(negedge CLK);
    A = a; B = b; CIN = cin; START = 1'b1;
    prev = SUM;
    @(negedge CLK);
    START = 1'b0;
    chk({tag, "_busy_e0"}, 32'(BUSY), 32'd1);
    chk({tag, "_done_e0"}, 32'(DONE), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(negedge CLK);
      chk({tag, "_busy_run"}, 32'(BUSY), 32'd1);
      chk({tag, "_done_run"}, 32'(DONE), 32'd0);
      chk({tag, "_sum_hold"}, 32'(SUM), 32'(prev));
    end
    @(negedge CLK);
    chk({tag, "_done"}, 32'(DONE), 32'd1);
    chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
    chk({tag, "_sum"}, 32'(SUM), 32'(es));
    chk({tag, "_cout"}, 32'(COUT), 32'(ec));
`ifdef CSA_OVF_EN
    chk({tag, "_ovf"}, 32'(OVF), 32'(eo));
`else
    if (eo === 1'bz) $display("note: unexpected z on ovf expectation");
`endif
    @(negedge CLK);
    chk({tag, "_done_drop"}, 32'(DONE), 32'd0);
    chk({tag, "_sum_keep"}, 32'(SUM), 32'(es));
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0; CIN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_sum",  32'(SUM),  32'd0);
    chk("rst_cout", 32'(COUT), 32'd0);
    RST = 1'b0;

    run_add("t1",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_add("t2",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_add("t3a",   16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_add("t3b",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_add("chain", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_add("t6a",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add("t6b",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // START held high throughout, operands disturbed mid-run.
    @(negedge CLK);
    A = 16'h1111; B = 16'h2222; CIN = 1'b0; START = 1'b1;
    @(negedge CLK);
    A = 16'hFFFF; B = 16'hFFFF; CIN = 1'b1;
    chk("t4_busy", 32'(BUSY), 32'd1);
    @(negedge CLK);
    A = 16'h0F0F; B = 16'h7777;
    repeat (2) @(negedge CLK);
    A = 16'hFFFF; B = 16'h0002; CIN = 1'b0;
    @(negedge CLK);
    chk("t4_done", 32'(DONE), 32'd1);
    chk("t4_sum",  32'(SUM),  32'h3333);
    chk("t4_cout", 32'(COUT), 32'd0);
    @(negedge CLK);
    chk("t4_fin_ignored_busy", 32'(BUSY), 32'd0);
    chk("t4_fin_ignored_done", 32'(DONE), 32'd0);
    @(negedge CLK);
    chk("t4_reaccept", 32'(BUSY), 32'd1);
    repeat (3) @(negedge CLK);
    chk("t4_hold_sum", 32'(SUM), 32'h3333);
    START = 1'b0;
    @(negedge CLK);
    chk("t4b_done", 32'(DONE), 32'd1);
    chk("t4b_sum",  32'(SUM),  32'h0001);
    chk("t4b_cout", 32'(COUT), 32'd1);

    // Asynchronous reset in the middle of an add.
    repeat (2) @(negedge CLK);
    A = 16'h1234; B = 16'h1111; CIN = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("t5_busy_pre", 32'(BUSY), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_done", 32'(DONE), 32'd0);
    chk("t5_sum",  32'(SUM),  32'd0);
    chk("t5_cout", 32'(COUT), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("t5_no_done", 32'(DONE), 32'd0);
      chk("t5_idle",    32'(BUSY), 32'd0);
    end
    run_add("t5_after", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
